mux_nx1_reg: RTL and testbench



---
 rtl/mux_nx1_reg_if.sv | 39 +++
 rtl/mux_nx1_reg.sv | 103 ++++++++++
 tb/tb_mux_nx1_reg.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mux_nx1_reg_if.sv
// Channel-side and consumer-side signal bundle for mux_nx1_reg.
// Optional out_par exists only when MUX_PARITY_EN is defined.
interface mux_nx1_reg_if #(
   parameter int N = 8,
   parameter int W = 1
);
   localparam int SELW = $clog2(N);

   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic            mode;
   logic [SELW-1:0] sel;
   logic            sel_load;
   logic [W-1:0]    out_data;
   logic [SELW-1:0] out_ch;
   logic            out_valid;
   logic            out_ready;
`ifdef MUX_PARITY_EN
   logic            out_par;
`endif

   // The master drives the producer channels and consumer ready; the mux is the slave.
   modport master (
      output in_data, in_valid, mode, sel, sel_load, out_ready,
      input  in_ready, out_data, out_ch, out_valid
`ifdef MUX_PARITY_EN
      , input out_par
`endif
   );

   modport slave (
      input  in_data, in_valid, mode, sel, sel_load, out_ready,
      output in_ready, out_data, out_ch, out_valid
`ifdef MUX_PARITY_EN
      , output out_par
`endif
   );
endinterface

// File: rtl/mux_nx1_reg.sv
// Registered N-to-1 channel mux with valid/ready handshake, fixed-select and round-robin modes.
// Define MUX_PARITY_EN to add the registered out_par parity bit.
module mux_nx1_reg #(
   parameter int N = 8,
   parameter int W = 1
) (
   input logic           clk,
   input logic           rst,
   mux_nx1_reg_if.slave  bus
);
   localparam int              SELW    = $clog2(N);
   localparam logic [SELW:0]   NUM_CH  = (SELW+1)'(N);
   localparam logic [SELW-1:0] LAST_CH = SELW'(N-1);

   logic [SELW-1:0] sel_reg;
   logic [SELW-1:0] ptr;
   logic [W-1:0]    out_data_q;
   logic [SELW-1:0] out_ch_q;
   logic            out_valid_q;

   logic            cap;
   logic [SELW-1:0] scan_ch;
   logic            scan_ok;
   int              scan_idx;
   logic [SELW-1:0] cand;
   logic            cand_ok;
   logic [W-1:0]    cand_data;
   logic [N-1:0]    ready;

   assign cap = !out_valid_q || bus.out_ready;

   // Round-robin search starting at ptr and wrapping at N, so no index ever reaches N.
   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      scan_ch  = '0;
      scan_ok  = 1'b0;
      scan_idx = 0;
      for (int i = 0; i < N; i++) begin
         scan_idx = int'(ptr) + i;
         if (scan_idx >= N) scan_idx = scan_idx - N;
         if (!scan_ok && bus.in_valid[scan_idx]) begin
            scan_ok = 1'b1;
            scan_ch = scan_idx[SELW-1:0];
         end
      end
   end

   always_comb begin
      if (bus.mode) begin
         cand    = scan_ch;
         cand_ok = scan_ok;
      end else begin
         cand    = sel_reg;
         cand_ok = bus.in_valid[sel_reg];
      end
      cand_data = bus.in_data[int'(cand)*W +: W];
   end

   always_comb begin
      ready = '0;
      if (!rst && cap && cand_ok) ready[cand] = 1'b1;
   end

   assign bus.in_ready  = ready;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;

`ifdef MUX_PARITY_EN
   logic out_par_q;
   assign bus.out_par = out_par_q;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_reg     <= '0;
         ptr         <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
`ifdef MUX_PARITY_EN
         out_par_q   <= 1'b0;
`endif
      end else begin
         // Out-of-range channel indices are dropped so sel_reg always names a real channel.
         if (bus.sel_load && ({1'b0, bus.sel} < NUM_CH)) sel_reg <= bus.sel;
         if (cap) begin
            if (cand_ok) begin
               out_data_q  <= cand_data;
               out_ch_q    <= cand;
               out_valid_q <= 1'b1;
`ifdef MUX_PARITY_EN
               out_par_q   <= ^cand_data;
`endif
               if (bus.mode) ptr <= (cand == LAST_CH) ? '0 : cand + SELW'(1);
            end else begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_mux_nx1_reg.sv
// Directed-vector bench for mux_nx1_reg: an N=8 and an N=5 instance, both W=4.
module tb_mux_nx1_reg;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mux_nx1_reg_if #(.N(8), .W(4)) bus8 ();
   mux_nx1_reg_if #(.N(5), .W(4)) bus5 ();

   mux_nx1_reg #(.N(8), .W(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   mux_nx1_reg #(.N(5), .W(4)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect8(input string tag, input logic v, input logic [2:0] ch, input logic [3:0] d);
      check({tag, ".valid"}, 32'(bus8.out_valid), 32'(v));
      check({tag, ".ch"},    32'(bus8.out_ch),    32'(ch));
      check({tag, ".data"},  32'(bus8.out_data),  32'(d));
   endtask

   initial begin
      // Reset with every channel valid: nothing may be accepted.
      rst = 1'b1;
      bus8.in_data  = 32'h7654_3213;
      bus8.in_valid = 8'hFF;
      bus8.mode     = 1'b0;
      bus8.sel      = '0;
      bus8.sel_load = 1'b0;
      bus8.out_ready = 1'b1;
      bus5.in_data  = '0;
      bus5.in_valid = '0;
      bus5.mode     = 1'b0;
      bus5.sel      = '0;
      bus5.sel_load = 1'b0;
      bus5.out_ready = 1'b1;
      tick();
      expect8("rst1", 1'b0, 3'd0, 4'h0);
      check("rst1.in_ready", 32'(bus8.in_ready), 32'h0);
      tick();
      check("rst2.valid", 32'(bus8.out_valid), 32'h0);
      check("rst2.in_ready", 32'(bus8.in_ready), 32'h0);
      check("rst2.valid5", 32'(bus5.out_valid), 32'h0);

      // Release: sel_reg=0 picks channel 0.
      rst = 1'b0;
      #1;
      check("rel.in_ready", 32'(bus8.in_ready), 32'h01);
      tick();
      expect8("rel", 1'b1, 3'd0, 4'h3);

      // Load sel=5 while nothing valid; the capture that cycle finds no data.
      bus8.in_valid = '0;
      bus8.sel      = 3'd5;
      bus8.sel_load = 1'b1;
      tick();
      check("empty.valid", 32'(bus8.out_valid), 32'h0);
      bus8.sel_load = 1'b0;
      bus8.in_data[5*4 +: 4] = 4'hA;
      bus8.in_valid = 8'b0010_0000;
      #1;
      check("fix.in_ready", 32'(bus8.in_ready), 32'h20);
      tick();
      expect8("fix", 1'b1, 3'd5, 4'hA);

      // Backpressure: hold A for three cycles while ch5 data changes.
      bus8.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus8.in_data[5*4 +: 4] = 4'(i + 4);
         #1;
         check("bp.in_ready", 32'(bus8.in_ready), 32'h0);
         tick();
         expect8("bp", 1'b1, 3'd5, 4'hA);
      end
      bus8.out_ready = 1'b1;
      #1;
      check("bp_rel.in_ready", 32'(bus8.in_ready), 32'h20);
      tick();
      expect8("bp_rel", 1'b1, 3'd5, 4'h6);

      // sel_load concurrent with capture: old sel_reg (5) wins this cycle.
      bus8.in_data[5*4 +: 4] = 4'h7;
      bus8.in_data[2*4 +: 4] = 4'h2;
      bus8.in_valid = 8'b0010_0100;
      bus8.sel      = 3'd2;
      bus8.sel_load = 1'b1;
      #1;
      check("sim.in_ready", 32'(bus8.in_ready), 32'h20);
      tick();
      expect8("sim_old", 1'b1, 3'd5, 4'h7);
      bus8.sel_load = 1'b0;
      #1;
      check("sim_new.in_ready", 32'(bus8.in_ready), 32'h04);
      tick();
      expect8("sim_new", 1'b1, 3'd2, 4'h2);

      // Round-robin from ptr=0 (held through fixed mode): 0, 2, 7, 0, 2.
      bus8.mode = 1'b1;
      bus8.in_data[0*4 +: 4] = 4'b1011;
      bus8.in_data[2*4 +: 4] = 4'b1001;
      bus8.in_data[7*4 +: 4] = 4'h7;
      bus8.in_valid = 8'b1000_0101;
      #1;
      check("rr.in_ready", 32'(bus8.in_ready), 32'h01);
      tick();
      expect8("rr0", 1'b1, 3'd0, 4'b1011);
`ifdef MUX_PARITY_EN
      check("par1", 32'(bus8.out_par), 32'h1);
`endif
      tick();
      expect8("rr1", 1'b1, 3'd2, 4'b1001);
`ifdef MUX_PARITY_EN
      check("par0", 32'(bus8.out_par), 32'h0);
`endif
      tick();
      expect8("rr2", 1'b1, 3'd7, 4'h7);
      tick();
      expect8("rr3", 1'b1, 3'd0, 4'b1011);
      tick();
      expect8("rr4", 1'b1, 3'd2, 4'b1001);

      // Idle: out_valid drops, data/ch hold, ptr stays at 3 so the scan resumes at 7.
      bus8.in_valid = '0;
      tick();
      expect8("idle", 1'b0, 3'd2, 4'b1001);
      bus8.in_valid = 8'b1000_0101;
      tick();
      expect8("resume", 1'b1, 3'd7, 4'h7);

      // N=5: load sel=3, then out-of-range sel=7 is ignored.
      bus5.sel      = 3'd3;
      bus5.sel_load = 1'b1;
      tick();
      bus5.sel      = 3'd7;
      bus5.in_data[3*4 +: 4] = 4'h9;
      bus5.in_valid = 5'b01000;
      tick();
      bus5.sel_load = 1'b0;
      tick();
      check("n5_sel.ch", 32'(bus5.out_ch), 32'h3);
      check("n5_sel.data", 32'(bus5.out_data), 32'h9);

      // N=5 round-robin: capture ch1 to set ptr=2, then ch4/ch1 alternate with wrap.
      bus5.mode = 1'b1;
      bus5.in_data[1*4 +: 4] = 4'h1;
      bus5.in_data[4*4 +: 4] = 4'h4;
      bus5.in_valid = 5'b00010;
      tick();
      check("n5_seed.ch", 32'(bus5.out_ch), 32'h1);
      bus5.in_valid = 5'b10010;
      #1;
      check("n5.in_ready", 32'(bus5.in_ready), 32'h10);
      tick();
      check("n5_rr0.ch", 32'(bus5.out_ch), 32'h4);
      check("n5_rr0.data", 32'(bus5.out_data), 32'h4);
      tick();
      check("n5_rr1.ch", 32'(bus5.out_ch), 32'h1);
      tick();
      check("n5_rr2.ch", 32'(bus5.out_ch), 32'h4);

      // Reset mid-operation drops the held word.
      bus8.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      expect8("rst_mid", 1'b0, 3'd0, 4'h0);
      check("rst_mid.valid5", 32'(bus5.out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
